// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_pkg                                                          |
// | Purpose : Shared types for the MEM stage and the MEM/WB register:          |
// |           MEM-stage state encoding, default widths and the writeback       |
// |           bundle record.                                                   |
// | Ports   : none (package)                                                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Writeback bundle shared with the MEM/WB register. The data field is sized
  // by the package width, so the MEM stage must be built with the same DATA_W.
  typedef struct packed {
    logic              wbs;
    logic              wce;
    logic              wme1;
    logic              wme2;
    logic [DATA_W-1:0] data;
  } wb_bundle_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_wait_timer                                                   |
// | Purpose : Counts cycles spent waiting for a data-memory acknowledge and    |
// |           flags when the wait budget is exhausted.                         |
// | Ports   : clk, rst_n      clock / async active-low reset                   |
// |           clear_i         force count to 0 (wins over enable)              |
// |           enable_i        advance count by one this edge                   |
// |           expired_o       count has reached TIMEOUT-1                      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      // Saturate at the last value so the counter never wraps back to a
      // "fresh" count while still enabled.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : memory_access_unit                                               |
// | Purpose : MEM stage. Consumes the EX/MEM register, runs the req/ack        |
// |           handshake to data RAM, stalls upstream while an access is        |
// |           pending and drives the registered MEM/WB bundle.                 |
// | Ports   : clk, rst_n                     clock / async active-low reset    |
// |           wbs/mm/wm/ni/wce/wme1/wme2_in  EX/MEM control                    |
// |           ALUresult_in, memData_in       ALU result/address, store data    |
// |           mem_req/we/addr/wdata          request to data RAM               |
// |           mem_ack, mem_rdata             completion from data RAM          |
// |           stall                          upstream hold (state==ACCESS)     |
// |           wb_valid, wbs/wce/wme1/wme2_out, wb_data, ALUresult_out  MEM/WB  |
// |           mem_err                        one-cycle timeout-abort pulse     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module memory_access_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_in,
  input  logic              mm_in,
  input  logic              wm_in,
  input  logic              ni_in,
  input  logic              wce_in,
  input  logic              wme1_in,
  input  logic              wme2_in,
  input  logic [DATA_W-1:0] ALUresult_in,
  input  logic [DATA_W-1:0] memData_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic              wbs_out,
  output logic              wce_out,
  output logic              wme1_out,
  output logic              wme2_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] ALUresult_out,
  output logic              mem_err
);

  mem_state_t        state_q,    state_d;
  logic              mem_req_q,  mem_req_d;
  logic              mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic              mem_err_q,  mem_err_d;
  wb_bundle_t        wb_q,       wb_d;
  logic [DATA_W-1:0] alu_out_q,  alu_out_d;

  // Captured op while the access is outstanding. hold_q.data keeps the ALU
  // result; hold_load_q is set only for a pure load (store wins over load).
  wb_bundle_t        hold_q,     hold_d;
  logic              hold_load_q, hold_load_d;

  logic              timer_clear;
  logic              timer_en;
  logic              timer_expired;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    wb_valid_d  = 1'b0;
    mem_err_d   = 1'b0;
    wb_d        = wb_q;
    alu_out_d   = alu_out_q;
    hold_d      = hold_q;
    hold_load_d = hold_load_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ni_in) begin
          wb_d      = '0;
          alu_out_d = '0;
        end else if (mm_in || wm_in) begin
          hold_d.wbs  = wbs_in;
          hold_d.wce  = wce_in;
          hold_d.wme1 = wme1_in;
          hold_d.wme2 = wme2_in;
          hold_d.data = ALUresult_in;
          hold_load_d = mm_in && !wm_in;
          mem_req_d   = 1'b1;
          mem_we_d    = wm_in;
          mem_addr_d  = ALUresult_in[ADDR_W-1:0];
          wdata_d     = memData_in;
          timer_clear = 1'b1;
          state_d     = ACCESS;
        end else begin
          wb_valid_d  = 1'b1;
          wb_d.wbs    = wbs_in;
          wb_d.wce    = wce_in;
          wb_d.wme1   = wme1_in;
          wb_d.wme2   = wme2_in;
          wb_d.data   = ALUresult_in;
          alu_out_d   = ALUresult_in;
        end
      end

      ACCESS: begin
        timer_en = 1'b1;
        // Ack is checked first so a completion on the final wait cycle is
        // still honoured rather than aborted.
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_d       = hold_q;
          wb_d.data  = hold_load_q ? mem_rdata : hold_q.data;
          alu_out_d  = hold_q.data;
          state_d    = IDLE;
        end else if (timer_expired) begin
          mem_req_d  = 1'b0;
          mem_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_d.wbs   = hold_q.wbs;
          wb_d.wce   = 1'b0;
          wb_d.wme1  = 1'b0;
          wb_d.wme2  = 1'b0;
          wb_d.data  = '0;
          alu_out_d  = hold_q.data;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      mem_err_q   <= 1'b0;
      wb_q        <= '0;
      alu_out_q   <= '0;
      hold_q      <= '0;
      hold_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      wb_valid_q  <= wb_valid_d;
      mem_err_q   <= mem_err_d;
      wb_q        <= wb_d;
      alu_out_q   <= alu_out_d;
      hold_q      <= hold_d;
      hold_load_q <= hold_load_d;
    end
  end

  assign stall         = (state_q == ACCESS);
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign mem_err       = mem_err_q;
  assign wbs_out       = wb_q.wbs;
  assign wce_out       = wb_q.wce;
  assign wme1_out      = wb_q.wme1;
  assign wme2_out      = wb_q.wme2;
  assign wb_data       = wb_q.data;
  assign ALUresult_out = alu_out_q;

endmodule : memory_access_unit
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_memory_access_unit                                            |
// | Purpose : Self-checking bench for memory_access_unit: a table of           |
// |           single-cycle ALU/bubble vectors, then directed load, store,      |
// |           timeout, store-priority and reset-abort sequences.               |
// | Ports   : none                                                             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_in = 0, mm_in = 0, wm_in = 0, ni_in = 1;
  logic        wce_in = 0, wme1_in = 0, wme2_in = 0;
  logic [15:0] ALUresult_in = '0, memData_in = '0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        stall, wb_valid, wbs_out, wce_out, wme1_out, wme2_out, mem_err;
  logic [15:0] wb_data, ALUresult_out;

  int n_total = 0;
  int n_pass  = 0;

  memory_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_in(wbs_in), .mm_in(mm_in), .wm_in(wm_in), .ni_in(ni_in),
    .wce_in(wce_in), .wme1_in(wme1_in), .wme2_in(wme2_in),
    .ALUresult_in(ALUresult_in), .memData_in(memData_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .wb_valid(wb_valid),
    .wbs_out(wbs_out), .wce_out(wce_out), .wme1_out(wme1_out), .wme2_out(wme2_out),
    .wb_data(wb_data), .ALUresult_out(ALUresult_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ni, input logic mm, input logic wm, input logic wbs,
                       input logic wce, input logic wme1, input logic wme2,
                       input logic [15:0] alu, input logic [15:0] md);
    ni_in = ni; mm_in = mm; wm_in = wm; wbs_in = wbs;
    wce_in = wce; wme1_in = wme1; wme2_in = wme2;
    ALUresult_in = alu; memData_in = md;
  endtask

  typedef struct {
    logic        ni, mm, wm, wbs, wce, wme1, wme2;
    logic [15:0] alu;
    logic        e_valid, e_wbs, e_wce, e_wme1, e_wme2;
    logic [15:0] e_data, e_aluo;
  } vec_t;

  vec_t vecs[6];

  int   cnt;

  initial begin
    //          ni mm wm wbs wce m1 m2 alu       valid wbs wce m1 m2 data      aluo
    vecs[0] = '{0, 0, 0, 0,  1,  0, 0, 16'h1234, 1,    0,  1,  0, 0, 16'h1234, 16'h1234};
    vecs[1] = '{0, 0, 0, 1,  0,  1, 1, 16'hFFFF, 1,    1,  0,  1, 1, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{1, 0, 0, 1,  1,  1, 1, 16'h5555, 0,    0,  0,  0, 0, 16'h0000, 16'h0000};
    vecs[3] = '{0, 0, 0, 0,  0,  0, 0, 16'h0000, 1,    0,  0,  0, 0, 16'h0000, 16'h0000};
    vecs[4] = '{0, 0, 0, 1,  1,  1, 1, 16'h8001, 1,    1,  1,  1, 1, 16'h8001, 16'h8001};
    vecs[5] = '{1, 1, 1, 1,  1,  1, 1, 16'hAAAA, 0,    0,  0,  0, 0, 16'h0000, 16'h0000};

    // Reset state
    #2;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_valid", wb_valid, 0);
    check("rst_data", wb_data, 0);
    check("rst_err", mem_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single-cycle ALU / bubble table
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].ni, vecs[i].mm, vecs[i].wm, vecs[i].wbs, vecs[i].wce,
            vecs[i].wme1, vecs[i].wme2, vecs[i].alu, 16'h0BAD);
      tick();
      check($sformatf("v%0d_valid", i), wb_valid, vecs[i].e_valid);
      check($sformatf("v%0d_wbs", i), wbs_out, vecs[i].e_wbs);
      check($sformatf("v%0d_wce", i), wce_out, vecs[i].e_wce);
      check($sformatf("v%0d_wme1", i), wme1_out, vecs[i].e_wme1);
      check($sformatf("v%0d_wme2", i), wme2_out, vecs[i].e_wme2);
      check($sformatf("v%0d_data", i), wb_data, vecs[i].e_data);
      check($sformatf("v%0d_aluo", i), ALUresult_out, vecs[i].e_aluo);
      check($sformatf("v%0d_stall", i), stall, 0);
      check($sformatf("v%0d_req", i), mem_req, 0);
    end

    // Load, ack sampled on the third edge after the request edge
    drive(0, 1, 0, 1, 1, 0, 1, 16'h0040, 16'h0000);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 16'hDEAD, 16'hDEAD);
    check("ld_req", mem_req, 1);
    check("ld_we", mem_we, 0);
    check("ld_addr", mem_addr, 16'h0040);
    cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      if (stall) cnt++;
      check($sformatf("ld_novalid%0d", i), wb_valid, 0);
      if (i == 3) begin mem_ack = 1; mem_rdata = 16'hABCD; end
      tick();
      mem_ack = 0;
    end
    check("ld_stall_cycles", cnt, 3);
    check("ld_valid", wb_valid, 1);
    check("ld_data", wb_data, 16'hABCD);
    check("ld_wbs", wbs_out, 1);
    check("ld_wme2", wme2_out, 1);
    check("ld_aluo", ALUresult_out, 16'h0040);
    check("ld_req_drop", mem_req, 0);
    check("ld_stall_drop", stall, 0);
    tick();
    check("ld_pulse", wb_valid, 0);

    // Store, ack on the next edge
    drive(0, 0, 1, 0, 1, 1, 0, 16'h4A81, 16'h7755);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    check("st_addr", mem_addr, 16'h4A81);
    check("st_wdata", mem_wdata, 16'h7755);
    mem_ack = 1; mem_rdata = 16'h9999;
    tick();
    mem_ack = 0;
    check("st_valid", wb_valid, 1);
    check("st_data", wb_data, 16'h4A81);
    check("st_wme1", wme1_out, 1);
    tick();
    check("st_pulse", wb_valid, 0);

    // Load that is never acknowledged
    drive(0, 1, 0, 1, 1, 1, 1, 16'h0100, 16'h0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h3333, 16'h0000);
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      if (mem_err) check("to_early_err", mem_err, 0);
      tick();
    end
    check("to_req_cycles", cnt, 15);
    check("to_err", mem_err, 1);
    check("to_valid", wb_valid, 1);
    check("to_wbs", wbs_out, 1);
    check("to_wce", wce_out, 0);
    check("to_wme1", wme1_out, 0);
    check("to_wme2", wme2_out, 0);
    check("to_data", wb_data, 0);
    check("to_stall", stall, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 16'h3333, 16'h0000);
    tick();
    check("to_err_pulse", mem_err, 0);
    check("to_next_valid", wb_valid, 1);
    check("to_next_data", wb_data, 16'h3333);
    check("to_next_wce", wce_out, 1);

    // Bubble with both memory flags, then store priority
    drive(1, 1, 1, 0, 0, 0, 0, 16'h2222, 16'h1111);
    tick();
    check("ni_req", mem_req, 0);
    check("ni_valid", wb_valid, 0);
    check("ni_stall", stall, 0);
    drive(0, 1, 1, 0, 1, 0, 0, 16'h2222, 16'h1111);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    check("pri_req", mem_req, 1);
    check("pri_we", mem_we, 1);
    mem_ack = 1; mem_rdata = 16'hEEEE;
    tick();
    mem_ack = 0;
    check("pri_valid", wb_valid, 1);
    check("pri_data", wb_data, 16'h2222);

    // Reset during an outstanding load
    drive(0, 1, 0, 1, 1, 1, 1, 16'h0080, 16'h0000);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    tick(); tick();
    check("ar_pre_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req", mem_req, 0);
    check("ar_stall", stall, 0);
    check("ar_addr", mem_addr, 0);
    check("ar_wbs", wbs_out, 0);
    check("ar_aluo", ALUresult_out, 0);
    tick(); tick();
    rst_n = 1'b1;
    mem_ack = 1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 0;
    check("ar_late_valid", wb_valid, 0);
    check("ar_late_req", mem_req, 0);
    tick();
    check("ar_late_valid2", wb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard ceiling on simulated time in case a sequence wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_memory_access_unit
`default_nettype wire
